// File: rtl/bubsys_ioctl_loader.sv
// HPS ioctl download consumer: packs ROM bytes into big-endian SDRAM words over a
// req/ack handshake, captures DIP-switch bytes, and reports ROM load completion.
module bubsys_ioctl_loader #(
  parameter logic [15:0] ROM_INDEX   = 16'd0,
  parameter logic [15:0] DIPSW_INDEX = 16'd254,
  parameter int          SDRAM_AW    = 24,
  parameter int          DIPSW_BYTES = 3
) (
  input  logic                     i_HPSIO_CLK,
  input  logic                     i_RST,
  input  logic                     i_IOCTL_DOWNLOAD,
  input  logic [15:0]              i_IOCTL_INDEX,
  input  logic [26:0]              i_IOCTL_ADDR,
  input  logic [7:0]               i_IOCTL_DATA,
  input  logic                     i_IOCTL_WR,
  output logic                     o_IOCTL_WAIT,
  output logic                     o_SDRAM_REQ,
  output logic [SDRAM_AW-1:0]      o_SDRAM_ADDR,
  output logic [15:0]              o_SDRAM_DATA,
  output logic [1:0]               o_SDRAM_BE,
  input  logic                     i_SDRAM_ACK,
  output logic [8*DIPSW_BYTES-1:0] o_DIPSW,
  output logic                     o_LOADING,
  output logic                     o_ROM_LOADED,
  output logic                     o_PROTO_ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROM, S_DIP, S_SKIP, S_WRITE, S_FLUSH, S_DONE
  } state_t;

  state_t                     r_state;
  logic                       r_wait;
  logic                       r_req;
  logic [SDRAM_AW-1:0]        r_addr;
  logic [15:0]                r_data;
  logic [1:0]                 r_be;
  logic [8*DIPSW_BYTES-1:0]   r_dipsw;
  logic                       r_loading;
  logic                       r_rom_loaded;
  logic                       r_proto_err;
  logic [7:0]                 r_pend;
  logic                       r_pend_vld;
  logic [SDRAM_AW-1:0]        r_pend_addr;

  logic                       w_addr_oob;
  logic [SDRAM_AW-1:0]        w_word;
  logic                       w_rom_wr;
  logic                       w_pend_hit;
  logic                       w_launch;
  logic [SDRAM_AW-1:0]        w_wr_addr;
  logic [15:0]                w_wr_data;
  logic [1:0]                 w_wr_be;

  // Bytes beyond the SDRAM word space are silently discarded.
  assign w_addr_oob = |(i_IOCTL_ADDR >> (SDRAM_AW + 1));
  assign w_word     = i_IOCTL_ADDR[SDRAM_AW:1];
  assign w_rom_wr   = i_IOCTL_WR & ~w_addr_oob;
  assign w_pend_hit = r_pend_vld && (r_pend_addr == w_word);

  // Write payload selection; the default is a flush of the pending even byte.
  always_comb begin
    w_launch  = 1'b0;
    w_wr_addr = r_pend_addr;
    w_wr_data = {r_pend, 8'h00};
    w_wr_be   = 2'b10;
    if (r_state == S_ROM) begin
      if (!i_IOCTL_DOWNLOAD) begin
        w_launch = r_pend_vld;
      end else if (w_rom_wr) begin
        if (!i_IOCTL_ADDR[0]) begin
          w_launch = r_pend_vld;
        end else begin
          w_launch  = 1'b1;
          w_wr_addr = w_word;
          if (w_pend_hit) begin
            w_wr_data = {r_pend, i_IOCTL_DATA};
            w_wr_be   = 2'b11;
          end else begin
            w_wr_data = {8'h00, i_IOCTL_DATA};
            w_wr_be   = 2'b01;
          end
        end
      end
    end
  end

  always_ff @(posedge i_HPSIO_CLK) begin
    if (!i_RST) begin
      r_state      <= S_IDLE;
      r_wait       <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_be         <= '0;
      r_dipsw      <= '1;
      r_loading    <= 1'b0;
      r_rom_loaded <= 1'b0;
      r_proto_err  <= 1'b0;
      r_pend       <= '0;
      r_pend_vld   <= 1'b0;
      r_pend_addr  <= '0;
    end else begin
      if (i_IOCTL_WR && r_wait) begin
        r_proto_err <= 1'b1;
      end

      if (w_launch) begin
        r_req  <= 1'b1;
        r_wait <= 1'b1;
        r_addr <= w_wr_addr;
        r_data <= w_wr_data;
        r_be   <= w_wr_be;
      end

      case (r_state)
        S_IDLE: begin
          // The index is sampled once here; later changes have no effect.
          if (i_IOCTL_DOWNLOAD) begin
            if (i_IOCTL_INDEX == ROM_INDEX) begin
              r_state      <= S_ROM;
              r_loading    <= 1'b1;
              r_rom_loaded <= 1'b0;
              r_pend_vld   <= 1'b0;
            end else if (i_IOCTL_INDEX == DIPSW_INDEX) begin
              r_state <= S_DIP;
            end else begin
              r_state <= S_SKIP;
            end
          end
        end

        S_ROM: begin
          if (!i_IOCTL_DOWNLOAD) begin
            r_pend_vld <= 1'b0;
            if (r_pend_vld) begin
              r_state <= S_FLUSH;
            end else begin
              r_state      <= S_DONE;
              r_loading    <= 1'b0;
              r_rom_loaded <= 1'b1;
            end
          end else if (w_rom_wr) begin
            if (!i_IOCTL_ADDR[0]) begin
              r_pend      <= i_IOCTL_DATA;
              r_pend_vld  <= 1'b1;
              r_pend_addr <= w_word;
            end else if (w_pend_hit) begin
              r_pend_vld <= 1'b0;
            end
            if (w_launch) begin
              r_state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (i_SDRAM_ACK) begin
            r_req   <= 1'b0;
            r_wait  <= 1'b0;
            r_state <= S_ROM;
          end
        end

        S_FLUSH: begin
          if (i_SDRAM_ACK) begin
            r_req        <= 1'b0;
            r_wait       <= 1'b0;
            r_state      <= S_DONE;
            r_loading    <= 1'b0;
            r_rom_loaded <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        S_DIP: begin
          if (!i_IOCTL_DOWNLOAD) begin
            r_state <= S_IDLE;
          end else if (i_IOCTL_WR) begin
            for (int n = 0; n < DIPSW_BYTES; n++) begin
              if (i_IOCTL_ADDR == 27'(n)) begin
                r_dipsw[8*n +: 8] <= i_IOCTL_DATA;
              end
            end
          end
        end

        S_SKIP: begin
          if (!i_IOCTL_DOWNLOAD) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_IOCTL_WAIT = r_wait;
  assign o_SDRAM_REQ  = r_req;
  assign o_SDRAM_ADDR = r_addr;
  assign o_SDRAM_DATA = r_data;
  assign o_SDRAM_BE   = r_be;
  assign o_DIPSW      = r_dipsw;
  assign o_LOADING    = r_loading;
  assign o_ROM_LOADED = r_rom_loaded;
  assign o_PROTO_ERR  = r_proto_err;

endmodule

// File: tb/tb_bubsys_ioctl_loader.sv
// Scoreboard bench for bubsys_ioctl_loader: expected SDRAM writes are queued by the
// stimulus side and checked by a monitor on each new write request.
module tb_bubsys_ioctl_loader;

  logic        clk = 1'b0;
  logic        i_RST;
  logic        i_IOCTL_DOWNLOAD;
  logic [15:0] i_IOCTL_INDEX;
  logic [26:0] i_IOCTL_ADDR;
  logic [7:0]  i_IOCTL_DATA;
  logic        i_IOCTL_WR;
  logic        o_IOCTL_WAIT;
  logic        o_SDRAM_REQ;
  logic [23:0] o_SDRAM_ADDR;
  logic [15:0] o_SDRAM_DATA;
  logic [1:0]  o_SDRAM_BE;
  logic        i_SDRAM_ACK;
  logic [23:0] o_DIPSW;
  logic        o_LOADING;
  logic        o_ROM_LOADED;
  logic        o_PROTO_ERR;

  always #5 clk = ~clk;

  bubsys_ioctl_loader dut (
    .i_HPSIO_CLK      (clk),
    .i_RST            (i_RST),
    .i_IOCTL_DOWNLOAD (i_IOCTL_DOWNLOAD),
    .i_IOCTL_INDEX    (i_IOCTL_INDEX),
    .i_IOCTL_ADDR     (i_IOCTL_ADDR),
    .i_IOCTL_DATA     (i_IOCTL_DATA),
    .i_IOCTL_WR       (i_IOCTL_WR),
    .o_IOCTL_WAIT     (o_IOCTL_WAIT),
    .o_SDRAM_REQ      (o_SDRAM_REQ),
    .o_SDRAM_ADDR     (o_SDRAM_ADDR),
    .o_SDRAM_DATA     (o_SDRAM_DATA),
    .o_SDRAM_BE       (o_SDRAM_BE),
    .i_SDRAM_ACK      (i_SDRAM_ACK),
    .o_DIPSW          (o_DIPSW),
    .o_LOADING        (o_LOADING),
    .o_ROM_LOADED     (o_ROM_LOADED),
    .o_PROTO_ERR      (o_PROTO_ERR)
  );

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;

  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   req_cnt = 0;
  int   wait_cnt = 0;
  bit   ack_en = 1'b1;
  bit   prev_req = 1'b0;

  // Reference model state: one pending even byte per ROM download.
  bit          m_vld;
  logic [7:0]  m_pend;
  logic [23:0] m_paddr;
  logic [7:0]  m_dip [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [23:0] a, input logic [15:0] d, input logic [1:0] b);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = b;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [26:0] a, input logic [7:0] d);
    logic [23:0] w;
    if (a >= 27'h2000000) return;
    w = a[24:1];
    if (!a[0]) begin
      if (m_vld) push(m_paddr, {m_pend, 8'h00}, 2'b10);
      m_pend  = d;
      m_paddr = w;
      m_vld   = 1'b1;
    end else if (m_vld && m_paddr == w) begin
      push(w, {m_pend, d}, 2'b11);
      m_vld = 1'b0;
    end else begin
      push(w, {8'h00, d}, 2'b01);
    end
  endfunction

  function automatic void model_end();
    if (m_vld) push(m_paddr, {m_pend, 8'h00}, 2'b10);
    m_vld = 1'b0;
  endfunction

  // SDRAM responder: random 0..3 cycle ack latency, single-cycle ack pulse.
  initial begin : responder
    int delay;
    i_SDRAM_ACK = 1'b0;
    delay = $urandom_range(0, 3);
    forever begin
      @(negedge clk);
      if (i_SDRAM_ACK) begin
        i_SDRAM_ACK = 1'b0;
        chk("req_drop_after_ack", {63'd0, o_SDRAM_REQ}, 64'd0);
        chk("wait_drop_after_ack", {63'd0, o_IOCTL_WAIT}, 64'd0);
      end else if (o_SDRAM_REQ && ack_en) begin
        if (delay == 0) begin
          i_SDRAM_ACK = 1'b1;
          delay = $urandom_range(0, 3);
        end else begin
          delay--;
        end
      end
    end
  end

  // Monitor: every new request is matched against the head of the scoreboard.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (o_SDRAM_REQ && !prev_req) begin
        req_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %0h data %0h be %0b, required no write",
                   o_SDRAM_ADDR, o_SDRAM_DATA, o_SDRAM_BE);
        end else begin
          e = exp_q.pop_front();
          $display("write addr=%0h data=%04h be=%02b", o_SDRAM_ADDR, o_SDRAM_DATA, o_SDRAM_BE);
          chk("wr_addr", {40'd0, o_SDRAM_ADDR}, {40'd0, e.addr});
          chk("wr_data", {48'd0, o_SDRAM_DATA}, {48'd0, e.data});
          chk("wr_be", {62'd0, o_SDRAM_BE}, {62'd0, e.be});
          chk("wait_with_req", {63'd0, o_IOCTL_WAIT}, 64'd1);
        end
      end
      prev_req = o_SDRAM_REQ;
      if (o_IOCTL_WAIT) wait_cnt++;
    end
  end

  task automatic wait_nowait();
    int n = 0;
    while (o_IOCTL_WAIT === 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL wait_timeout: WAIT=%b after %0d cycles, required 0", o_IOCTL_WAIT, n);
        break;
      end
    end
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    wait_nowait();
    i_IOCTL_ADDR = a;
    i_IOCTL_DATA = d;
    i_IOCTL_WR   = 1'b1;
    @(negedge clk);
    i_IOCTL_WR   = 1'b0;
  endtask

  task automatic start_dl(input logic [15:0] idx);
    i_IOCTL_INDEX    = idx;
    i_IOCTL_DOWNLOAD = 1'b1;
    m_vld            = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_rom_dl(input string name);
    int n = 0;
    wait_nowait();
    i_IOCTL_DOWNLOAD = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (o_LOADING && n < 100);
    chk({name, "_loading_end"}, {63'd0, o_LOADING}, 64'd0);
    chk({name, "_rom_loaded"}, {63'd0, o_ROM_LOADED}, 64'd1);
    chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    int r0, w0, n;
    logic [26:0] a;
    logic [7:0]  d;
    int base;

    i_RST = 1'b0;
    i_IOCTL_DOWNLOAD = 1'b0;
    i_IOCTL_INDEX = 16'd0;
    i_IOCTL_ADDR = '0;
    i_IOCTL_DATA = '0;
    i_IOCTL_WR = 1'b0;
    for (int i = 0; i < 3; i++) m_dip[i] = 8'hFF;

    repeat (3) @(negedge clk);
    chk("rst_req", {63'd0, o_SDRAM_REQ}, 64'd0);
    chk("rst_wait", {63'd0, o_IOCTL_WAIT}, 64'd0);
    chk("rst_loaded", {63'd0, o_ROM_LOADED}, 64'd0);
    chk("rst_loading", {63'd0, o_LOADING}, 64'd0);
    chk("rst_proto", {63'd0, o_PROTO_ERR}, 64'd0);
    chk("rst_dipsw", {40'd0, o_DIPSW}, 64'hFFFFFF);
    i_RST = 1'b1;
    @(negedge clk);

    // Directed: two full words.
    start_dl(16'd0);
    chk("rom1_loading", {63'd0, o_LOADING}, 64'd1);
    push(24'd0, 16'h1234, 2'b11);
    push(24'd1, 16'h5678, 2'b11);
    send_byte(27'd0, 8'h12);
    send_byte(27'd1, 8'h34);
    send_byte(27'd2, 8'h56);
    send_byte(27'd3, 8'h78);
    end_rom_dl("rom1");
    $display("rom1 done loaded=%b", o_ROM_LOADED);

    // Directed: odd byte count, trailing flush.
    start_dl(16'd0);
    chk("rom2_loaded_cleared", {63'd0, o_ROM_LOADED}, 64'd0);
    push(24'd0, 16'hAABB, 2'b11);
    push(24'd1, 16'hCC00, 2'b10);
    send_byte(27'd0, 8'hAA);
    send_byte(27'd1, 8'hBB);
    send_byte(27'd2, 8'hCC);
    end_rom_dl("rom2");
    $display("rom2 done loaded=%b", o_ROM_LOADED);

    // Randomized ROM downloads against the reference model.
    for (int t = 0; t < 8; t++) begin
      start_dl(16'd0);
      n = $urandom_range(1, 16);
      base = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0:       a = 27'h2000000 + 27'($urandom_range(0, 255));
          1:       a = 27'($urandom_range(0, 63));
          default: a = 27'(base + i);
        endcase
        d = 8'($urandom);
        model_byte(a, d);
        send_byte(a, d);
      end
      model_end();
      end_rom_dl("rom_rand");
      $display("rom_rand %0d: %0d bytes from %0d", t, n, base);
    end

    // Unknown index: everything ignored.
    r0 = req_cnt;
    w0 = wait_cnt;
    start_dl(16'd5);
    for (int i = 0; i < 16; i++) send_byte(27'(i), 8'($urandom));
    chk("skip_loading", {63'd0, o_LOADING}, 64'd0);
    i_IOCTL_DOWNLOAD = 1'b0;
    repeat (3) @(negedge clk);
    chk("skip_no_req", 64'(req_cnt - r0), 64'd0);
    chk("skip_no_wait", 64'(wait_cnt - w0), 64'd0);
    chk("skip_loaded_kept", {63'd0, o_ROM_LOADED}, 64'd1);
    $display("skip done");

    // DIP switches, with an index change mid-download that must be ignored.
    r0 = req_cnt;
    w0 = wait_cnt;
    start_dl(16'd254);
    send_byte(27'd0, 8'hFE);
    send_byte(27'd1, 8'h7F);
    i_IOCTL_INDEX = 16'd0;
    send_byte(27'd2, 8'h01);
    send_byte(27'd3, 8'h55);
    i_IOCTL_DOWNLOAD = 1'b0;
    repeat (3) @(negedge clk);
    chk("dip_value", {40'd0, o_DIPSW}, 64'h017FFE);
    chk("dip_no_req", 64'(req_cnt - r0), 64'd0);
    chk("dip_no_wait", 64'(wait_cnt - w0), 64'd0);
    $display("dip directed dipsw=%06h", o_DIPSW);
    m_dip[0] = 8'hFE;
    m_dip[1] = 8'h7F;
    m_dip[2] = 8'h01;

    start_dl(16'd254);
    for (int i = 0; i < 6; i++) begin
      a = 27'($urandom_range(0, 5));
      d = 8'($urandom);
      if (a < 27'd3) m_dip[a[1:0]] = d;
      send_byte(a, d);
    end
    i_IOCTL_DOWNLOAD = 1'b0;
    repeat (3) @(negedge clk);
    chk("dip_rand", {40'd0, o_DIPSW}, {40'd0, m_dip[2], m_dip[1], m_dip[0]});
    $display("dip random dipsw=%06h", o_DIPSW);

    // Protocol error: WR while WAIT is held high.
    ack_en = 1'b0;
    start_dl(16'd0);
    push(24'd0, 16'h1122, 2'b11);
    send_byte(27'd0, 8'h11);
    send_byte(27'd1, 8'h22);
    chk("proto_wait_high", {63'd0, o_IOCTL_WAIT}, 64'd1);
    chk("proto_before", {63'd0, o_PROTO_ERR}, 64'd0);
    i_IOCTL_ADDR = 27'd2;
    i_IOCTL_DATA = 8'h99;
    i_IOCTL_WR   = 1'b1;
    @(negedge clk);
    i_IOCTL_WR   = 1'b0;
    chk("proto_err_set", {63'd0, o_PROTO_ERR}, 64'd1);
    ack_en = 1'b1;
    end_rom_dl("proto");
    $display("proto done err=%b", o_PROTO_ERR);

    // Reset while a request is outstanding.
    ack_en = 1'b0;
    start_dl(16'd0);
    push(24'd3, 16'h0042, 2'b01);
    send_byte(27'd7, 8'h42);
    chk("midrst_req_up", {63'd0, o_SDRAM_REQ}, 64'd1);
    i_RST = 1'b0;
    i_IOCTL_DOWNLOAD = 1'b0;
    @(negedge clk);
    chk("midrst_req_drop", {63'd0, o_SDRAM_REQ}, 64'd0);
    chk("midrst_wait_drop", {63'd0, o_IOCTL_WAIT}, 64'd0);
    chk("midrst_proto_clr", {63'd0, o_PROTO_ERR}, 64'd0);
    repeat (2) @(negedge clk);
    i_RST = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_loaded", {63'd0, o_ROM_LOADED}, 64'd0);
    chk("midrst_dipsw", {40'd0, o_DIPSW}, 64'hFFFFFF);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("reset mid-request done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
